train_sensor_conditioner: RTL and testbench

- Upstream stage of the train-controller FSM. Produces the controller's `y` event input from raw track-sensor contacts.
- Each of N asynchronous, bouncy sensor lines is synchronized and debounced. Rising edges are converted into pending events.
- Events are presented one at a time, lowest index first. The controller consumes each event with a one-cycle `ack`.

---
 rtl/train_pkg.sv | 17 +
 rtl/sensor_debounce.sv | 64 ++++++
 rtl/train_sensor_conditioner.sv | 84 ++++++++
 tb/tb_train_sensor_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// Shared constants and types for the train-controller sensor path.
package train_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int N_SENSORS_DEFAULT       = 4;

  // Width needed to index n items, never less than one bit.
  function automatic int idWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SENSOR_ID_W = idWidth(N_SENSORS_DEFAULT);

  // Sensor index as seen by the controller.
  typedef logic [SENSOR_ID_W-1:0] sensor_idx_t;

endpackage

// File: rtl/sensor_debounce.sv
// One track-sensor channel: two-flop synchronizer, debounce counter and a
// single-cycle pulse on the edge where the debounced level goes 0 -> 1.
module sensor_debounce
  import train_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous contact into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreements; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounced level and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/train_sensor_conditioner.sv
// Turns N bouncy track contacts into a queue of one-at-a-time rise events
// for the train controller, lowest sensor index served first.
module train_sensor_conditioner
  import train_pkg::*;
#(
  parameter  int N_SENSORS       = N_SENSORS_DEFAULT,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int ID_W            = idWidth(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SENSORS-1:0] sensor_raw,
  input  logic                 ack,
  output logic                 y,
  output logic [ID_W-1:0]      sensor_id,
  output logic [N_SENSORS-1:0] sensor_stable,
  output logic                 overrun
);

  logic [N_SENSORS-1:0] riseVec;
  logic [N_SENSORS-1:0] ackSel;
  logic [N_SENSORS-1:0] pending_q;
  logic [N_SENSORS-1:0] pending_d;
  logic                 overrun_q;
  logic                 overrun_d;

  for (genvar g = 0; g < N_SENSORS; g++) begin : gChannel
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (sensor_raw[g]),
      .stable_o(sensor_stable[g]),
      .rise_o  (riseVec[g])
    );
  end

  // Present the lowest pending index and decode which flag an ack retires.
  always_comb begin
    y         = |pending_q;
    sensor_id = '0;
    ackSel    = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sensor_id = ID_W'(i);
      end
    end
    for (int i = 0; i < N_SENSORS; i++) begin
      ackSel[i] = ack & y & (sensor_id == ID_W'(i));
    end
  end

  // Retire the acked flag, latch new rises, and flag a rise on a busy channel.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (ackSel[i]) begin
        pending_d[i] = 1'b0;
      end
      if (riseVec[i]) begin
        if (pending_q[i] && !ackSel[i]) begin
          overrun_d = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
  end

  // Pending flags and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_train_sensor_conditioner.sv
// Directed bench for train_sensor_conditioner with a scoreboard of expected
// event ids, consumed by a monitor whenever an event is acked.
module tb_train_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic [3:0] sensor_raw = 4'h0;
  logic       y;
  logic [1:0] sensor_id;
  logic [3:0] sensor_stable;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int expQ[$];

  always #5 clk = ~clk;

  train_sensor_conditioner #(
    .N_SENSORS      (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .ack          (ack),
    .y            (y),
    .sensor_id    (sensor_id),
    .sensor_stable(sensor_stable),
    .overrun      (overrun)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw, input logic rstVal);
    sensor_raw = raw;
    rst        = rstVal;
  endtask

  task automatic ackOnce();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  // Every consumed event must match the next expected id.
  always @(negedge clk) begin : monitor
    int e;
    if (ack === 1'b1 && y === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_event: got id %0d expected none", sensor_id);
      end else begin
        e = expQ.pop_front();
        if (sensor_id !== e[1:0]) begin
          bad++;
          $display("[TB] FAIL event_id: got %0d expected %0d", sensor_id, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset with all contacts closed
    applyStimulus(4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rst_y", y, 0);
      checkOutput("rst_id", sensor_id, 0);
      checkOutput("rst_stable", sensor_stable, 0);
      checkOutput("rst_overrun", overrun, 0);
    end
    applyStimulus(4'hF, 1'b0);
    expQ.push_back(0); expQ.push_back(1); expQ.push_back(2); expQ.push_back(3);
    tick(5);
    checkOutput("post_rst_early_stable", sensor_stable, 4'h0);
    checkOutput("post_rst_early_y", y, 0);
    tick(1);
    checkOutput("post_rst_stable", sensor_stable, 4'hF);
    checkOutput("post_rst_y", y, 1);
    checkOutput("post_rst_id", sensor_id, 0);
    for (int i = 0; i < 4; i++) ackOnce();
    checkOutput("post_rst_drained", y, 0);
    applyStimulus(4'h0, 1'b0);
    tick(6);
    checkOutput("fall_stable", sensor_stable, 4'h0);
    checkOutput("fall_no_event", y, 0);

    // Clean rise on channel 2
    applyStimulus(4'h4, 1'b0);
    expQ.push_back(2);
    tick(5);
    checkOutput("ch2_early_stable", sensor_stable, 4'h0);
    tick(1);
    checkOutput("ch2_stable", sensor_stable, 4'h4);
    checkOutput("ch2_y", y, 1);
    checkOutput("ch2_id", sensor_id, 2);
    ackOnce();
    checkOutput("ch2_acked", y, 0);

    // Bounce on channel 1 then settle high
    applyStimulus(4'h6, 1'b0);
    tick(2);
    applyStimulus(4'h4, 1'b0);
    tick(2);
    applyStimulus(4'h6, 1'b0);
    expQ.push_back(1);
    tick(5);
    checkOutput("bounce_early_stable", sensor_stable, 4'h4);
    checkOutput("bounce_early_y", y, 0);
    tick(1);
    checkOutput("bounce_stable", sensor_stable, 4'h6);
    checkOutput("bounce_id", sensor_id, 1);
    ackOnce();
    tick(8);
    checkOutput("bounce_single_event", y, 0);

    // Simultaneous rises on channels 0 and 3
    applyStimulus(4'hF, 1'b0);
    expQ.push_back(0); expQ.push_back(3);
    tick(6);
    checkOutput("prio_stable", sensor_stable, 4'hF);
    checkOutput("prio_first_id", sensor_id, 0);
    ackOnce();
    checkOutput("prio_second_y", y, 1);
    checkOutput("prio_second_id", sensor_id, 3);
    ackOnce();
    checkOutput("prio_drained", y, 0);

    // Overrun: second rise on channel 1 while its event is unacked
    applyStimulus(4'h0, 1'b0);
    tick(6);
    checkOutput("ovr_idle_stable", sensor_stable, 4'h0);
    applyStimulus(4'h2, 1'b0);
    expQ.push_back(1);
    tick(6);
    checkOutput("ovr_first_id", sensor_id, 1);
    checkOutput("ovr_first_flag", overrun, 0);
    applyStimulus(4'h0, 1'b0);
    tick(6);
    checkOutput("ovr_fallen_stable", sensor_stable, 4'h0);
    checkOutput("ovr_still_pending", y, 1);
    applyStimulus(4'h2, 1'b0);
    tick(5);
    checkOutput("ovr_before_rise", overrun, 0);
    tick(1);
    checkOutput("ovr_set", overrun, 1);
    checkOutput("ovr_id", sensor_id, 1);
    ackOnce();
    checkOutput("ovr_drained", y, 0);
    tick(10);
    checkOutput("ovr_sticky", overrun, 1);

    // Ack coinciding with a new rise on the presented channel
    applyStimulus(4'h0, 1'b1);
    tick(1);
    checkOutput("rst2_overrun", overrun, 0);
    checkOutput("rst2_y", y, 0);
    applyStimulus(4'h4, 1'b0);
    expQ.push_back(2);
    tick(6);
    checkOutput("col_first_id", sensor_id, 2);
    applyStimulus(4'h0, 1'b0);
    tick(6);
    checkOutput("col_fallen_y", y, 1);
    applyStimulus(4'h4, 1'b0);
    expQ.push_back(2);
    tick(5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checkOutput("col_stable", sensor_stable, 4'h4);
    checkOutput("col_y", y, 1);
    checkOutput("col_id", sensor_id, 2);
    checkOutput("col_overrun", overrun, 0);
    ackOnce();
    checkOutput("col_drained", y, 0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
